// File: rtl/stb_gen_pkg.sv
// Shared types and sizing helpers for the averaging strobe generator.
package stb_gen_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    MEASURE    = 3'd2,
    RUN        = 3'd3,
    ERR        = 3'd4
  } state_e;

  function automatic int acc_width(input int cnt_w, input int avg_log2);
    return cnt_w + avg_log2;
  endfunction

  function automatic int round_const(input int avg_log2);
    return 1 << (avg_log2 - 1);
  endfunction

endpackage

// File: rtl/stb_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a
// registered rising-edge detector producing a 1-cycle pulse.
module stb_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/stb_gen_avg.sv
// Period-averaging strobe generator: measures 2^AVG_LOG2 input periods,
// then free-runs a phase-offset strobe, continuous or single-shot.
module stb_gen_avg
  import stb_gen_pkg::*;
#(
  parameter int T_CNT_WIDTH = 32,
  parameter int AVG_LOG2    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sig_i,
  input  logic                   run_det_i,
  input  logic [T_CNT_WIDTH-1:0] phase_i,
  input  logic                   continuous_i,
  input  logic                   oe_i,
  input  logic                   stb_req_i,
  output logic                   stb_o,
  output logic                   debug_stb_o,
  output logic                   stb_valid_o,
  output logic                   rdy_o,
  output logic                   err_o,
  output logic [T_CNT_WIDTH-1:0] stb_period_o
);

  localparam int TW = T_CNT_WIDTH;
  localparam int AW = acc_width(TW, AVG_LOG2);
  localparam logic [AW:0]         RND   = (AW+1)'(round_const(AVG_LOG2));
  localparam logic [AVG_LOG2-1:0] NLAST = '1;
  localparam logic [TW-1:0]       CMAX  = '1;

  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       pc_q, pc_d;
  logic [TW-1:0]       phase_q, phase_d;
  logic [TW-1:0]       period_q, period_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [AVG_LOG2-1:0] nsmp_q, nsmp_d;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic                dbg_q, dbg_d;
  logic                stb_q, stb_d;
  logic                vld_q, vld_d;

  logic          edge_w;
  logic [TW-1:0] cnt_inc;
  logic [AW-1:0] acc_sum;
  logic [AW:0]   rnd_sum;
  logic [TW:0]   avg;
  logic          avg_bad;
  logic          done;
  logic          match;

  stb_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sig_i (sig_i),
    .edge_o(edge_w)
  );

  // The completing edge is the pc=0 cycle, so phase 0 matches there.
  always_comb begin
    cnt_inc = cnt_q + TW'(1);
    acc_sum = acc_q + AW'(cnt_q);
    rnd_sum = {1'b0, acc_sum} + RND;
    avg     = rnd_sum[AW:AVG_LOG2];
    avg_bad = avg[TW] | (avg < (TW+1)'(2)) | ({1'b0, phase_q} >= avg);
    done    = (state_q == MEASURE) & edge_w & (nsmp_q == NLAST);
    match   = ((state_q == RUN) & (pc_q == phase_q))
            | (done & ~avg_bad & (phase_q == '0));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    phase_d  = phase_q;
    period_d = period_q;
    acc_d    = acc_q;
    nsmp_d   = nsmp_q;
    rdy_d    = rdy_q;
    err_d    = err_q;
    armed_d  = armed_q;
    dbg_d    = match;
    stb_d    = 1'b0;
    vld_d    = 1'b0;

    if (continuous_i) begin
      stb_d = match & oe_i;
    end else if (match & armed_q & oe_i) begin
      stb_d   = 1'b1;
      vld_d   = 1'b1;
      armed_d = 1'b0;
    end
    // A request on a match cycle arms the following period.
    if (~continuous_i & stb_req_i & rdy_q) armed_d = 1'b1;

    unique case (state_q)
      IDLE: ;
      WAIT_FIRST: begin
        cnt_d = cnt_inc;
        if (edge_w) begin
          cnt_d   = TW'(1);
          state_d = MEASURE;
        end else if (cnt_inc == CMAX) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        if (edge_w) begin
          acc_d  = acc_sum;
          nsmp_d = nsmp_q + AVG_LOG2'(1);
          cnt_d  = TW'(1);
          if (done) begin
            if (avg_bad) begin
              state_d = ERR;
              err_d   = 1'b1;
            end else begin
              period_d = avg[TW-1:0];
              pc_d     = TW'(1);
              state_d  = RUN;
              rdy_d    = 1'b1;
            end
          end
        end else if (cnt_inc == CMAX) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        pc_d = (pc_q == period_q - TW'(1)) ? '0 : pc_q + TW'(1);
      end
      ERR: begin
        rdy_d = 1'b0;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (run_det_i) begin
      state_d = WAIT_FIRST;
      cnt_d   = '0;
      err_d   = 1'b0;
      rdy_d   = 1'b0;
      acc_d   = '0;
      nsmp_d  = '0;
      armed_d = 1'b0;
      phase_d = phase_i;
      dbg_d   = 1'b0;
      stb_d   = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pc_q     <= '0;
      phase_q  <= '0;
      period_q <= '0;
      acc_q    <= '0;
      nsmp_q   <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
      dbg_q    <= 1'b0;
      stb_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      acc_q    <= acc_d;
      nsmp_q   <= nsmp_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
      dbg_q    <= dbg_d;
      stb_q    <= stb_d;
      vld_q    <= vld_d;
    end
  end

  assign stb_o        = stb_q;
  assign debug_stb_o  = dbg_q;
  assign stb_valid_o  = vld_q;
  assign rdy_o        = rdy_q;
  assign err_o        = err_q;
  assign stb_period_o = period_q;

endmodule

// File: doc/stb_gen_avg.md
Name: stb_gen_avg

Overview:
- Next-generation strobe generator for the measure unit.
- Measures the period of the asynchronous comparator output as a rounded average over 2^AVG_LOG2 consecutive periods, then free-runs a strobe at that period with a programmable phase offset.
- Supports continuous mode, and single-shot mode with a request/valid handshake.
- Sits between the comparator input and the sampling/capture logic.

Parameters:
- T_CNT_WIDTH, 32, width of period counter, phase input and stb_period_o.
- AVG_LOG2, 3, log2 of number of periods averaged (1..8).
- SYNC_STAGES, 2, synchroniser flops on sig_i (>=2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- sig_i  in  1  asynchronous comparator output; rising edges are measured.
- run_det_i  in  1  start/restart detection; level, acted on every cycle it is high.
- phase_i  in  T_CNT_WIDTH  strobe delay in clocks after the period reference; sampled on the last cycle run_det_i is high.
- continuous_i  in  1  1 = strobe every period; 0 = single-shot on request.
- oe_i  in  1  output enable for stb_o.
- stb_req_i  in  1  single-shot request pulse.
- stb_o  out  1  gated strobe, 1-cycle pulse.
- debug_stb_o  out  1  ungated strobe, every period while running.
- stb_valid_o  out  1  1-cycle pulse coincident with a single-shot stb_o.
- rdy_o  out  1  period measured, generator running.
- err_o  out  1  measurement error, sticky.
- stb_period_o  out  T_CNT_WIDTH  averaged period in clocks.

Behaviour:
- Reset: state IDLE; all outputs 0; stb_period_o=0; accumulator, counters and armed flag cleared.
- Input path: sig_i passes through SYNC_STAGES flops, then a rising-edge detector gives a 1-cycle edge pulse. Edges are visible SYNC_STAGES+1 cycles after the input transition.
- run_det_i high in any state:
  - goto WAIT_FIRST.
  - clear err_o, rdy_o, acc, sample count, armed.
  - latch phase_i into phase_q.
- WAIT_FIRST:
  - cnt increments each cycle.
  - on edge: cnt<=1, goto MEASURE.
  - cnt reaching all-ones: goto ERR.
- MEASURE:
  - on edge cycle: sample = cnt; acc += sample (acc width T_CNT_WIDTH+AVG_LOG2); nsmp++; cnt<=1.
  - otherwise cnt++.
  - saturation at all-ones: goto ERR.
- End of measurement, on the edge that completes 2^AVG_LOG2 samples:
  - period = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, i.e. round half up.
  - period < 2, or phase_q >= period: goto ERR.
  - else: stb_period_o<=period; pc<=1; goto RUN.
  - rdy_o=1 from the following cycle.
- RUN:
  - pc counts 0..period-1 and wraps to 0. The final measurement edge cycle is pc=0.
  - sig_i is ignored; the generator free-runs with no tracking.
  - match = (pc==phase_q). debug_stb_o is registered and pulses the cycle after a match.
  - Exactly one pulse per period; spacing equals stb_period_o.
- ERR: err_o=1, rdy_o=0, strobes off. Remains until run_det_i or rst_i.
- Continuous mode (continuous_i=1): stb_o = registered (match & oe_i). stb_valid_o stays 0.
- Single-shot mode (continuous_i=0):
  - stb_req_i while rdy_o sets armed; ignored when not rdy.
  - on the next match with armed & oe_i: stb_o=1 and stb_valid_o=1 for one cycle, armed cleared.
  - match with oe_i=0 leaves armed set.
  - req in the same cycle as a match arms for the following period, not the current one.
- Mode change takes effect on the next match.
- Outputs are registered throughout; no combinational path from input to output.

Decomposition:
- stb_gen_pkg holds:
  - state_e enum: IDLE, WAIT_FIRST, MEASURE, RUN, ERR.
  - localparam functions for acc width and rounding constant.
- Sub-module stb_sync_edge: parametrised SYNC_STAGES synchroniser plus rising-edge detector; output is a 1-cycle pulse.

Test Plan:
- Period: sig_i period 125 clk, 20 ns high, AVG_LOG2=3, phase 0, continuous -> rdy_o after 9th detected edge; stb_period_o=125; debug_stb_o spacing 125 clk for 10 consecutive pulses.
- Rounding: periods alternating 100/101 clk -> acc=804 -> stb_period_o=101. All periods 100 -> stb_period_o=100.
- Phase: phase_i=30, period 125 -> debug_stb_o 31 clk after the pc=0 reference cycle, repeating every 125. phase_i=125 -> err_o=1, rdy_o=0, no strobes.
- Single-shot: continuous_i=0, one stb_req_i pulse -> exactly one stb_o with coincident stb_valid_o. With oe_i=0 the strobe is withheld and debug_stb_o continues; raising oe_i later -> one stb_o. Req on the match cycle -> strobe in the next period.
- Timeout: T_CNT_WIDTH=8, run_det_i then no edges -> err_o=1 after 255 clk. A subsequent run_det_i clears err_o and measurement resumes.
- Reset/restart: rst_i mid-RUN -> next cycle all outputs 0, state IDLE. run_det_i mid-MEASURE -> acc cleared; new stb_period_o reflects only post-restart edges (change period 80 -> 60 -> result 60).
